// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants for the LEGv8 fetch stage.
//   FETCH_ADDR_W    default PC / ROM word-address width
//   FETCH_INSTR_W   default instruction width
//   FETCH_RESET_PC  default PC after reset
//   INSTR_BR_XZR    ROM fill word (BR XZR)
//   INSTR_NOP       canonical A64 NOP, for decode-side bubbles and benches
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W   = 16;
  localparam int unsigned FETCH_INSTR_W  = 32;
  localparam logic [15:0] FETCH_RESET_PC = 16'd0;

  localparam logic [31:0] INSTR_BR_XZR = 32'hD600_03E0;
  localparam logic [31:0] INSTR_NOP    = 32'hD503_201F;

  // Buffer depth is fixed at two; count encodes 0..2.
  localparam logic [1:0] BUF_DEPTH = 2'd2;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry circular FIFO of {pc, instr} pairs.
//   clock, reset      rising-edge clock, synchronous active-low reset
//   flush             drops all entries; overrides push and pop
//   push, push_pc,
//   push_instr        write one entry at the tail
//   pop               retire the head entry (caller guarantees count != 0)
//   count             occupancy 0..2
//   head_valid        head holds an entry
//   head_pc,
//   head_instr        head entry contents, straight from storage registers
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = FETCH_ADDR_W,
  parameter int unsigned INSTR_W = FETCH_INSTR_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic               pop,
  output logic [1:0]         count,
  output logic               head_valid,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [INSTR_W-1:0] head_instr
);

  logic [ADDR_W-1:0]  pc_q    [2];
  logic [INSTR_W-1:0] instr_q [2];
  logic               rd_ptr_q;
  logic               wr_ptr_q;
  logic [1:0]         count_q;
  logic [1:0]         count_d;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      // Storage contents are left alone; only occupancy and pointers matter.
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        pc_q[wr_ptr_q]    <= push_pc;
        instr_q[wr_ptr_q] <= push_instr;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != 2'd0);
  assign head_pc    = pc_q[rd_ptr_q];
  assign head_instr = instr_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: LEGv8 fetch stage.
//   clock           rising-edge clock
//   reset           synchronous active-low reset
//   rom_address     ROM word address, driven directly by the PC register
//   rom_data        combinational ROM word for rom_address
//   redirect_valid  execute redirect request (highest priority)
//   redirect_pc     absolute redirect target word address
//   inst_valid      buffer head valid
//   inst_ready      decode accepts the head this cycle
//   inst, inst_pc   head instruction and its word address
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned       INSTR_W  = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
  input  logic               clock,
  input  logic               reset,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INSTR_W-1:0] inst,
  output logic [ADDR_W-1:0]  inst_pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [1:0]        count;
  logic              full;
  logic              pop;
  logic              push;

  assign full = (count == BUF_DEPTH);
  assign pop  = inst_valid & inst_ready;
  // A full buffer still accepts a word when the head leaves on the same edge.
  assign push = ~redirect_valid & (~full | pop);

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc;
    end else if (push) begin
      pc_q <= pc_q + ADDR_W'(1);  // wraps silently at the top of the space
    end
  end

  assign rom_address = pc_q;

  // On redirect the flush wins over pop, so a handshake that edge is squashed.
  fetch_buffer #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_fetch_buffer (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_pc    (pc_q),
    .push_instr (rom_data),
    .pop        (pop),
    .count      (count),
    .head_valid (inst_valid),
    .head_pc    (inst_pc),
    .head_instr (inst)
  );

endmodule
